pio_blink_out: RTL and testbench

Parametrised Avalon-MM output PIO, the successor of the fixed 14-bit LED PIO. It is generalised to WIDTH bits and adds atomic set, clear and toggle registers, plus a per-bit hardware blink mode driven by a programmable half-period timer. It sits on the SoC system interconnect as a slave and drives LED or pin outputs through out_port.

---
 rtl/pio_blink_pkg.sv | 22 ++
 rtl/pio_blink_timer.sv | 57 +++++
 rtl/pio_blink_out.sv | 120 ++++++++++++
 tb/tb_pio_blink_out.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pio_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_blink_pkg
// Description : Shared constants for the blinking output PIO: the Avalon-MM
//               register word addresses decoded by pio_blink_out.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pio_blink_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_TOGGLE   = 3'd6;

endpackage : pio_blink_pkg
`default_nettype wire

// File: rtl/pio_blink_timer.sv
`default_nettype none
// ============================================================================
// Module      : pio_blink_timer
// Description : Half-period blink timer. Counts 0..period-1 and flips phase on
//               every wrap; period==0 halts it with phase high. restart forces
//               cnt=0 / phase=1 and overrides a wrap due on the same edge.
// Ports       : clk, reset_n      - clock, async active-low reset
//               period [PERIOD_W] - half-period in clocks (0 = halted)
//               restart           - synchronous counter/phase restart
//               phase             - registered blink phase
//               tick              - combinational, high on the edge that wraps
// Revision    : 1.0 - initial release
// ============================================================================
module pio_blink_timer #(
  parameter int unsigned PERIOD_W = 26
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                wrap;

  always_comb begin
    wrap    = (period != '0) && (cnt_q == (period - PERIOD_W'(1)));
    cnt_d   = cnt_q + PERIOD_W'(1);
    phase_d = phase_q;
    if (restart || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // A restart wins over a wrap, so no tick is reported on that edge.
  assign tick  = wrap & ~restart;
  assign phase = phase_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule : pio_blink_timer
`default_nettype wire

// File: rtl/pio_blink_out.sv
`default_nettype none
// ============================================================================
// Module      : pio_blink_out
// Description : Avalon-MM output PIO, WIDTH bits, with atomic set/clear/toggle
//               registers and per-bit hardware blink driven by a programmable
//               half-period timer.
// Ports       : clk, reset_n          - clock, async active-low reset
//               address [3]           - register word address
//               chipselect, write_n   - write when chipselect & !write_n
//               writedata [32]        - write data
//               readdata [32]         - combinational read data
//               out_port [WIDTH]      - registered output pins
// Revision    : 1.0 - initial release
// ============================================================================
module pio_blink_out
  import pio_blink_pkg::*;
#(
  parameter int unsigned             WIDTH        = 14,
  parameter logic [WIDTH-1:0]        RESET_VALUE  = '0,
  parameter int unsigned             PERIOD_W     = 26,
  parameter logic [PERIOD_W-1:0]     RESET_PERIOD = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    blink_en_q, blink_en_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [WIDTH-1:0]    out_port_q, out_port_d;

  logic                wr_en;
  logic                restart;
  logic                phase;
  logic                tick;
  logic                phase_next;
  logic [WIDTH-1:0]    wd_data;
  logic [PERIOD_W-1:0] wd_period;
  logic                unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd_data   = writedata[WIDTH-1:0];
  assign wd_period = writedata[PERIOD_W-1:0];
  assign unused_wd = ^writedata;

  pio_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_q),
    .restart (restart),
    .phase   (phase),
    .tick    (tick)
  );

  // Timer's next phase. While period is 0 the phase register is already 1
  // (only reset or a PERIOD write can get it there) and tick stays low, so
  // this expression also covers the halted case.
  assign phase_next = restart | (phase ^ tick);

  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    restart    = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d     = wd_data;
        ADDR_BLINK_EN: blink_en_d = wd_data;
        ADDR_PERIOD: begin
          period_d = wd_period;
          restart  = 1'b1;
        end
        ADDR_OUTSET:   data_d     = data_q | wd_data;
        ADDR_OUTCLEAR: data_d     = data_q & ~wd_data;
        ADDR_TOGGLE:   data_d     = data_q ^ wd_data;
        default: ;
      endcase
    end
    // Built from next-state values so a register write shows on the pins at
    // the same edge the register updates.
    out_port_d = data_d & ~(blink_en_d & {WIDTH{~phase_next}});
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]    = data_q;
      ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_en_q;
      ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS:   readdata[0]            = phase;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= RESET_PERIOD;
      out_port_q <= RESET_VALUE;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      out_port_q <= out_port_d;
    end
  end

  assign out_port = out_port_q;

endmodule : pio_blink_out
`default_nettype wire

// File: tb/tb_pio_blink_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_blink_out
// Description : Self-checking bench for pio_blink_out (WIDTH=14,
//               RESET_VALUE=0x0A5, PERIOD_W=26, RESET_PERIOD=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_blink_out;

  localparam int W = 14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [2:0]   wa;
    logic [31:0]  wd;
    logic [2:0]   ra;
    logic [31:0]  exp_rd;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  pio_blink_out #(
    .WIDTH        (W),
    .RESET_VALUE  (14'h0A5),
    .PERIOD_W     (26),
    .RESET_PERIOD (26'd0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input string nm);
    logic [W-1:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got empty scoreboard expected one entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk(nm, 32'(out_port), 32'(e));
    end
  endtask

  // Called at edge+1; the write is sampled on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [W-1:0] e_out,
                    input string nm);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    sb_q.push_back(e_out);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    pop_chk(nm);
  endtask

  task automatic idle(input logic [W-1:0] e_out, input string nm);
    sb_q.push_back(e_out);
    @(posedge clk);
    #1;
    pop_chk(nm);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    address = a;
    #1;
    chk(nm, readdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ph;
    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 3'd0, 32'h0000_3FFF, 14'h3FFF};
    vecs[1]  = '{3'd5, 32'h0000_000F, 3'd0, 32'h0000_3FF0, 14'h3FF0};
    vecs[2]  = '{3'd4, 32'h0000_0003, 3'd0, 32'h0000_3FF3, 14'h3FF3};
    vecs[3]  = '{3'd6, 32'h0000_3000, 3'd0, 32'h0000_0FF3, 14'h0FF3};
    vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 3'd1, 32'h0000_3FFF, 14'h0FF3};
    vecs[5]  = '{3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000, 14'h0FF3};
    vecs[6]  = '{3'd3, 32'hFFFF_FFFF, 3'd3, 32'h0000_0001, 14'h0FF3};
    vecs[7]  = '{3'd7, 32'hFFFF_FFFF, 3'd0, 32'h0000_0FF3, 14'h0FF3};
    vecs[8]  = '{3'd2, 32'hFFFF_FFFF, 3'd2, 32'h03FF_FFFF, 14'h0FF3};
    vecs[9]  = '{3'd2, 32'h0000_0000, 3'd2, 32'h0000_0000, 14'h0FF3};
    vecs[10] = '{3'd4, 32'h0000_0000, 3'd4, 32'h0000_0000, 14'h0FF3};

    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #12;
    chk("rst_out", 32'(out_port), 32'h0A5);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state of all registers
    rd(3'd0, 32'h0000_00A5, "rst_data");
    rd(3'd1, 32'h0, "rst_blink_en");
    rd(3'd2, 32'h0, "rst_period");
    rd(3'd3, 32'h1, "rst_status");
    rd(3'd7, 32'h0, "rst_rd7");
    idle(14'h0A5, "rst_out_hold");

    // Register map / set-clear-toggle table
    for (int i = 0; i < 11; i++) begin
      wr(vecs[i].wa, vecs[i].wd, vecs[i].exp_out, $sformatf("tbl_out%0d", i));
      rd(vecs[i].ra, vecs[i].exp_rd, $sformatf("tbl_rd%0d", i));
    end

    // Blink with PERIOD=4: bit0 high 4 clks, low 4 clks
    wr(3'd0, 32'h3, 14'h3, "blk_data");
    wr(3'd1, 32'h1, 14'h3, "blk_en");
    wr(3'd2, 32'h4, 14'h3, "blk_period");
    rd(3'd3, 32'h1, "blk_status0");
    for (int k = 1; k <= 21; k++) begin
      ph = (((k / 4) % 2) == 0);
      idle(ph ? 14'h3 : 14'h2, $sformatf("blk_out%0d", k));
      rd(3'd3, 32'(ph), $sformatf("blk_status%0d", k));
    end

    // Now phase=0 mid half-period: rewrite PERIOD=4 restarts the timer
    wr(3'd2, 32'h4, 14'h3, "rst4_out");
    rd(3'd3, 32'h1, "rst4_status");
    for (int j = 1; j <= 4; j++)
      idle((j == 4) ? 14'h2 : 14'h3, $sformatf("rst4_out%0d", j));

    // PERIOD=1 toggles every clock, then PERIOD=0 halts with phase=1
    wr(3'd2, 32'h1, 14'h3, "p1_out0");
    for (int j = 1; j <= 6; j++)
      idle((j % 2 == 1) ? 14'h2 : 14'h3, $sformatf("p1_out%0d", j));
    wr(3'd2, 32'h0, 14'h3, "p0_out0");
    for (int j = 1; j <= 4; j++)
      idle(14'h3, $sformatf("p0_out%0d", j));
    rd(3'd3, 32'h1, "p0_status");

    // Asynchronous reset mid-blink
    wr(3'd2, 32'h4, 14'h3, "ar_period");
    for (int j = 1; j <= 5; j++)
      idle((j >= 4) ? 14'h2 : 14'h3, $sformatf("ar_out%0d", j));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_async", 32'(out_port), 32'h0A5);
    rd(3'd0, 32'h0A5, "ar_data");
    rd(3'd1, 32'h0, "ar_blink_en");
    rd(3'd2, 32'h0, "ar_period_rd");
    rd(3'd3, 32'h1, "ar_status");
    @(posedge clk);
    #1;
    chk("ar_out_held", 32'(out_port), 32'h0A5);
    reset_n = 1'b1;
    rd(3'd7, 32'h0, "ar_rd7");
    rd(3'd5, 32'h0, "ar_rd5");
    rd(3'd6, 32'h0, "ar_rd6");
    // BLINK_EN was cleared, so a fast period must not disturb the pins
    wr(3'd2, 32'h1, 14'h0A5, "ar_noblink0");
    idle(14'h0A5, "ar_noblink1");
    idle(14'h0A5, "ar_noblink2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pio_blink_out
`default_nettype wire
